// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared constants and types for the PPU sprite pixel path.
//   - OAM attribute byte bit positions (palette, priority, horizontal flip)
//   - sp_slot_t : the state held by one per-line sprite slot
//   - sp_pix_t  : the pixel a slot presents to the priority mux
//   - bit_rev8  : byte bit reversal used for horizontal flip at load time
// ---------------------------------------------------------------------------
package ppu_pkg;

  // OAM byte 2 (attribute) layout
  localparam int SP_ATTR_PAL_LSB = 0;
  localparam int SP_ATTR_PAL_MSB = 1;
  localparam int SP_ATTR_PRI     = 5;  // 1 = sprite behind background
  localparam int SP_ATTR_HFLIP   = 6;

  // X value of an empty slot; together with an all-zero pattern it never
  // produces a visible pixel during a 256-pixel line.
  localparam logic [7:0] SP_X_IDLE = 8'hFF;

  // Width of the left-edge clip window and the last screen column,
  // which never reports a sprite-0 hit.
  localparam logic [7:0] SP_CLIP_W = 8'd8;
  localparam logic [7:0] SP_X_LAST = 8'd255;

  typedef struct packed {
    logic [7:0] x;     // pixels remaining until the sprite starts
    logic [7:0] pat0;  // pattern low plane, MSB is the next pixel out
    logic [7:0] pat1;  // pattern high plane
    logic [1:0] pal;   // palette select
    logic       pri;   // priority: 1 = behind background
    logic       sp0;   // slot holds OAM sprite 0
  } sp_slot_t;

  typedef struct packed {
    logic [1:0] px;    // 0 = transparent
    logic [1:0] pal;
    logic       pri;
    logic       sp0;
  } sp_pix_t;

  localparam sp_slot_t SP_SLOT_CLEAR = '{
    x:    SP_X_IDLE,
    pat0: 8'h00,
    pat1: 8'h00,
    pal:  2'b00,
    pri:  1'b0,
    sp0:  1'b0
  };

  // Reverse bit order of a pattern byte (horizontal flip).
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// ---------------------------------------------------------------------------
// sprite_slot
// One per-line sprite slot: X down-counter plus two pattern shift registers.
// Loaded during HBLANK, advanced once per visible pixel.
//   clk, rst   pixel clock, asynchronous active-low reset
//   clear      make the slot transparent (loses to load)
//   load       write this slot from the load_* bus (wins over clear/shift)
//   load_*     OAM X, attribute byte, pattern planes, sprite-0 flag
//   shift      advance one visible pixel
//   pix        current pixel of this slot (state before this cycle's update)
// ---------------------------------------------------------------------------
module sprite_slot
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_x,
  input  logic [7:0] load_attr,
  input  logic [7:0] load_pat0,
  input  logic [7:0] load_pat1,
  input  logic       load_sp0,
  input  logic       shift,
  output sp_pix_t    pix
);

  sp_slot_t slot;
  sp_slot_t slot_load;

  // Attribute bits 2..4 and 7 are not used by the pixel path.
  logic unused_attr;
  assign unused_attr = ^{load_attr[7], load_attr[4:2]};

  // Flip is applied once here so the shifter always emits from the MSB.
  always_comb begin
    // NOTE: every field is assigned unconditionally in this block, so no
    // latch can be inferred for slot_load.
    slot_load.x    = load_x;
    slot_load.pat0 = load_attr[SP_ATTR_HFLIP] ? bit_rev8(load_pat0) : load_pat0;
    slot_load.pat1 = load_attr[SP_ATTR_HFLIP] ? bit_rev8(load_pat1) : load_pat1;
    slot_load.pal  = load_attr[SP_ATTR_PAL_MSB:SP_ATTR_PAL_LSB];
    slot_load.pri  = load_attr[SP_ATTR_PRI];
    slot_load.sp0  = load_sp0;
  end

  // Priority inside the slot: load > clear > shift.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every slot
    // samples the pre-edge values of its neighbours and inputs.
    if (!rst) begin
      slot <= SP_SLOT_CLEAR;
    end else if (load) begin
      slot <= slot_load;
    end else if (clear) begin
      slot <= SP_SLOT_CLEAR;
    end else if (shift) begin
      if (slot.x != 8'd0) begin
        // Counter stops at zero; it never wraps back to 0xFF.
        slot.x <= slot.x - 8'd1;
      end else begin
        // After eight shifts both planes are zero and the slot is
        // transparent for the rest of the line.
        slot.pat0 <= {slot.pat0[6:0], 1'b0};
        slot.pat1 <= {slot.pat1[6:0], 1'b0};
      end
    end
  end

  assign pix.px  = (slot.x == 8'd0) ? {slot.pat1[7], slot.pat0[7]} : 2'b00;
  assign pix.pal = slot.pal;
  assign pix.pri = slot.pri;
  assign pix.sp0 = slot.sp0;

endmodule

// File: rtl/sprite_render.sv
// ---------------------------------------------------------------------------
// sprite_render
// PPU sprite pixel engine: N_SPRITES per-line slots, lowest-index priority
// mux, left-edge clipping and sprite-0 hit detection. Outputs are registered
// and appear one cycle after the px_en that evaluated them.
//   clk, rst            pixel clock, asynchronous active-low reset
//   clear               make every slot transparent
//   load_en, load_slot  write one slot (out-of-range slot numbers ignored)
//   load_x, load_attr   OAM byte 3 / byte 2
//   load_pat0/1         pattern planes (vertical flip already applied)
//   load_sp0            loaded slot holds OAM sprite 0
//   px_en, px_x         advance one visible pixel at screen column px_x
//   show_left           sprites visible in columns 0..7
//   bg_opaque           background pixel at px_x is non-zero
//   sp_px/sp_pal/sp_pri winning sprite pixel, palette and priority
//   sp0_hit             one-cycle sprite-0 hit pulse
// ---------------------------------------------------------------------------
module sprite_render
  import ppu_pkg::*;
#(
  parameter int N_SPRITES = 8,
  parameter int SLOT_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_en,
  input  logic [SLOT_W-1:0] load_slot,
  input  logic [7:0]        load_x,
  input  logic [7:0]        load_attr,
  input  logic [7:0]        load_pat0,
  input  logic [7:0]        load_pat1,
  input  logic              load_sp0,
  input  logic              px_en,
  input  logic [7:0]        px_x,
  input  logic              show_left,
  input  logic              bg_opaque,
  output logic [1:0]        sp_px,
  output logic [1:0]        sp_pal,
  output logic              sp_pri,
  output logic              sp0_hit
);

  sp_pix_t pix [N_SPRITES];

  // Slot array. A slot number with no matching instance never decodes,
  // which is how out-of-range loads are dropped.
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
    logic load_hit;
    assign load_hit = load_en && (load_slot == SLOT_W'(g));

    sprite_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .load      (load_hit),
      .load_x    (load_x),
      .load_attr (load_attr),
      .load_pat0 (load_pat0),
      .load_pat1 (load_pat1),
      .load_sp0  (load_sp0),
      .shift     (px_en),
      .pix       (pix[g])
    );
  end

  // Lowest-index opaque slot wins. Sprite-0 hit looks at every sp0 slot,
  // not only the winner, so a higher-priority sprite covering sprite 0
  // does not hide the hit.
  sp_pix_t win;
  logic    found;
  logic    sp0_opaque;

  always_comb begin
    win        = '0;
    found      = 1'b0;
    sp0_opaque = 1'b0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (pix[i].px != 2'b00) begin
        if (!found) begin
          win   = pix[i];
          found = 1'b1;
        end
        if (pix[i].sp0) begin
          sp0_opaque = 1'b1;
        end
      end
    end
  end

  logic clipped;
  logic hit_next;

  assign clipped  = !show_left && (px_x < SP_CLIP_W);
  // Column 255 never reports a hit.
  assign hit_next = sp0_opaque && bg_opaque && (px_x != SP_X_LAST) && !clipped;

  // Outputs only carry a pixel in the cycle after px_en; otherwise zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_px   <= 2'b00;
      sp_pal  <= 2'b00;
      sp_pri  <= 1'b0;
      sp0_hit <= 1'b0;
    end else if (px_en) begin
      sp_px   <= clipped ? 2'b00 : win.px;
      sp_pal  <= win.pal;
      sp_pri  <= win.pri;
      sp0_hit <= hit_next;
    end else begin
      sp_px   <= 2'b00;
      sp_pal  <= 2'b00;
      sp_pri  <= 1'b0;
      sp0_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_render.sv
// ---------------------------------------------------------------------------
// tb_sprite_render
// Drives an 8-slot and a 16-slot sprite_render with the same stimulus.
// Expected outputs come from a screen-space model: a sprite loaded with X
// covers columns X..X+7 of the following line, column c showing bit 7-c of
// its (flipped) pattern. Expectations are queued when a pixel is driven and
// popped when the registered output appears one cycle later.
// ---------------------------------------------------------------------------
module tb_sprite_render;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       load_en;
  logic [3:0] load_slot;
  logic [7:0] load_x;
  logic [7:0] load_attr;
  logic [7:0] load_pat0;
  logic [7:0] load_pat1;
  logic       load_sp0;
  logic       px_en;
  logic [7:0] px_x;
  logic       show_left;
  logic       bg_opaque;

  logic [1:0] px8, pal8, px16, pal16;
  logic       pri8, hit8, pri16, hit16;
  logic       load_en8;

  // The 8-slot instance only sees loads addressed to slots it owns.
  assign load_en8 = load_en && (load_slot < 4'd8);

  always #5 clk = ~clk;

  sprite_render #(.N_SPRITES(8)) u8 (
    .clk(clk), .rst(rst), .clear(clear), .load_en(load_en8),
    .load_slot(load_slot[2:0]), .load_x(load_x), .load_attr(load_attr),
    .load_pat0(load_pat0), .load_pat1(load_pat1), .load_sp0(load_sp0),
    .px_en(px_en), .px_x(px_x), .show_left(show_left), .bg_opaque(bg_opaque),
    .sp_px(px8), .sp_pal(pal8), .sp_pri(pri8), .sp0_hit(hit8)
  );

  sprite_render #(.N_SPRITES(16)) u16 (
    .clk(clk), .rst(rst), .clear(clear), .load_en(load_en),
    .load_slot(load_slot), .load_x(load_x), .load_attr(load_attr),
    .load_pat0(load_pat0), .load_pat1(load_pat1), .load_sp0(load_sp0),
    .px_en(px_en), .px_x(px_x), .show_left(show_left), .bg_opaque(bg_opaque),
    .sp_px(px16), .sp_pal(pal16), .sp_pri(pri16), .sp0_hit(hit16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- screen-space reference model ----------------
  bit         m_on  [2][16];
  int         m_x   [2][16];
  logic [7:0] m_p0  [2][16];
  logic [7:0] m_p1  [2][16];
  logic [1:0] m_pal [2][16];
  logic       m_pri [2][16];
  logic       m_sp0 [2][16];

  logic [5:0] sb8  [$];
  logic [5:0] sb16 [$];
  string      cur_test = "reset";

  function automatic logic [7:0] flip8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  // Returns {sp_px, sp_pal, sp_pri, sp0_hit} for screen column p.
  function automatic logic [5:0] model_eval(input int d, input int p);
    int         n;
    logic [1:0] px, pal;
    logic       pri, hit;
    bit         found, clip;
    n = (d == 0) ? 8 : 16;
    px = 2'b00; pal = 2'b00; pri = 1'b0; hit = 1'b0; found = 0;
    clip = !show_left && (p < 8);
    for (int s = 0; s < n; s++) begin
      if (m_on[d][s] && p >= m_x[d][s] && p < m_x[d][s] + 8) begin
        logic [1:0] v;
        int         col;
        col = p - m_x[d][s];
        v = {m_p1[d][s][7-col], m_p0[d][s][7-col]};
        if (v != 2'b00) begin
          if (!found) begin
            found = 1; px = v; pal = m_pal[d][s]; pri = m_pri[d][s];
          end
          if (m_sp0[d][s]) hit = 1'b1;
        end
      end
    end
    hit = hit && bg_opaque && (p != 255) && !clip;
    if (clip) px = 2'b00;
    return {px, pal, pri, hit};
  endfunction

  task automatic model_clear_all();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++) m_on[d][s] = 0;
  endtask

  // One clock: queue expectations from pre-edge model state, apply
  // clear/load to the model, clock, then compare the registered outputs.
  task automatic step(input bit en, input int x);
    int s;
    px_en = en;
    px_x  = 8'(x);
    sb8.push_back(en ? model_eval(0, x) : 6'd0);
    sb16.push_back(en ? model_eval(1, x) : 6'd0);
    if (clear) model_clear_all();
    if (load_en) begin
      s = int'(load_slot);
      for (int d = 0; d < 2; d++) begin
        if (s < ((d == 0) ? 8 : 16)) begin
          m_on[d][s]  = 1;
          m_x[d][s]   = int'(load_x);
          m_p0[d][s]  = load_attr[6] ? flip8(load_pat0) : load_pat0;
          m_p1[d][s]  = load_attr[6] ? flip8(load_pat1) : load_pat1;
          m_pal[d][s] = load_attr[1:0];
          m_pri[d][s] = load_attr[5];
          m_sp0[d][s] = load_sp0;
        end
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("%s n8 px_x=%0d", cur_test, x), {26'd0, px8, pal8, pri8, hit8}, {26'd0, sb8.pop_front()});
    check($sformatf("%s n16 px_x=%0d", cur_test, x), {26'd0, px16, pal16, pri16, hit16}, {26'd0, sb16.pop_front()});
    clear   = 1'b0;
    load_en = 1'b0;
    px_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(0, 0);
  endtask

  task automatic load(input int slot, input logic [7:0] x, input logic [7:0] a,
                      input logic [7:0] p0, input logic [7:0] p1, input logic sp0,
                      input bit with_clear = 0, input bit en = 0, input int px = 0);
    load_en   = 1'b1;
    load_slot = 4'(slot);
    load_x    = x;
    load_attr = a;
    load_pat0 = p0;
    load_pat1 = p1;
    load_sp0  = sp0;
    clear     = with_clear;
    step(en, px);
  endtask

  // Pixels first..last, then one idle cycle (outputs must return to 0).
  task automatic line(input int first, input int last);
    for (int i = first; i <= last; i++) step(1, i);
    step(0, 0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; load_en = 1'b0; load_slot = '0; load_x = '0;
    load_attr = '0; load_pat0 = '0; load_pat1 = '0; load_sp0 = 1'b0;
    px_en = 1'b0; px_x = '0; show_left = 1'b1; bg_opaque = 1'b0;
    model_clear_all();

    repeat (3) @(posedge clk);
    #1;
    check("reset n8 outputs", {26'd0, px8, pal8, pri8, hit8}, 32'd0);
    check("reset n16 outputs", {26'd0, px16, pal16, pri16, hit16}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Slots come out of reset transparent.
    cur_test = "post_reset";
    line(0, 9);

    cur_test = "t1_basic";
    do_clear();
    load(0, 8'd3, 8'h01, 8'h80, 8'h00, 1'b0);
    line(0, 9);

    cur_test = "t2_hflip";
    do_clear();
    load(0, 8'd3, 8'h41, 8'h01, 8'h00, 1'b0);
    line(0, 9);

    cur_test = "t3_priority";
    do_clear();
    load(1, 8'd10, 8'h02, 8'hFF, 8'h00, 1'b0);
    load(5, 8'd10, 8'h23, 8'h00, 8'hFF, 1'b0);
    line(0, 19);

    cur_test = "t4_clip";
    do_clear();
    show_left = 1'b0;
    bg_opaque = 1'b1;
    load(2, 8'd4, 8'h00, 8'hFF, 8'h00, 1'b1);
    line(0, 13);
    show_left = 1'b1;

    cur_test = "t5_col255";
    do_clear();
    load(4, 8'd250, 8'h00, 8'hFF, 8'h00, 1'b1);
    line(0, 255);
    bg_opaque = 1'b0;

    // Load + clear + px_en in one cycle: slot 3 keeps its load (X not
    // decremented), slot 0 is cleared; the pixel that cycle still sees slot 0.
    cur_test = "t6_simul";
    do_clear();
    load(0, 8'd0, 8'h00, 8'hFF, 8'hFF, 1'b0);
    load(3, 8'd2, 8'h03, 8'hC0, 8'h00, 1'b0, 1, 1, 0);
    line(0, 9);

    // Slot 15 only exists in the 16-slot instance and loses to slot 7.
    cur_test = "t6_slot15";
    do_clear();
    load(15, 8'd0, 8'h03, 8'hFF, 8'h00, 1'b0);
    load(7, 8'd4, 8'h21, 8'h00, 8'hF0, 1'b0);
    line(0, 11);

    // Asynchronous reset in the middle of a line.
    cur_test = "midline_rst";
    do_clear();
    load(0, 8'd0, 8'h02, 8'hFF, 8'hFF, 1'b0);
    px_en = 1'b1;
    px_x  = 8'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midline_rst n8 async clear", {26'd0, px8, pal8, pri8, hit8}, 32'd0);
    check("midline_rst n16 async clear", {26'd0, px16, pal16, pri16, hit16}, 32'd0);
    px_en = 1'b0;
    model_clear_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    line(0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
